// File: rtl/ab_seq_pkg.sv
// Shared definitions for the A/B serial stimulus sequencer: default sizes and
// the playback state encoding.
package ab_seq_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int HOLD_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/ab_seq_mem.sv
// Program store for the sequencer: one synchronous write port and one
// combinational read port.
module ab_seq_mem #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; the program must survive rst, and a
  // resettable array cannot be mapped onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ab_seq_gen.sv
// Programmable A/B serial stimulus generator: plays entries {A, B, hold} from
// a small program memory, each held for hold+1 cycles, once or looping.
module ab_seq_gen
  import ab_seq_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int HOLD_W = HOLD_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [HOLD_W+1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] len,
  input  logic                     start,
  input  logic                     loop,
  input  logic                     stop,
  output logic                     A,
  output logic                     B,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] step
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = HOLD_W + 2;

  state_e            state_q, state_d;
  logic [AW-1:0]     step_q, step_d;
  logic [AW-1:0]     len_q, len_d;
  logic              loop_q, loop_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              a_q, a_d;
  logic              b_q, b_d;

  logic              mem_we;
  logic              last;
  logic [AW-1:0]     rd_addr;
  logic [EW-1:0]     rd_data;
  logic [EW-1:0]     entry;

  // The program is frozen while playing.
  assign mem_we = wr_en && (state_q != ST_PLAY);

  ab_seq_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (mem_we),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign last    = (step_q == len_q);
  // The read port always presents the entry that would be loaded next.
  assign rd_addr = (state_q == ST_PLAY && !last) ? step_q + 1'b1 : '0;
  // Forward a same-cycle write so a start sees the entry being written.
  assign entry   = (mem_we && (wr_addr == rd_addr)) ? wr_data : rd_data;

  // NOTE: every variable gets a default before the case so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    len_d   = len_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d            = ST_PLAY;
          len_d              = len;
          loop_d             = loop;
          step_d             = '0;
          {a_d, b_d, cnt_d}  = entry;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          state_d = ST_IDLE;
          step_d  = '0;
          cnt_d   = '0;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!last || loop_q) begin
          step_d            = rd_addr;
          {a_d, b_d, cnt_d} = entry;
        end else begin
          state_d = ST_FIN;
          step_d  = '0;
          cnt_d   = '0;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
        cnt_d   = '0;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign A    = a_q;
  assign B    = b_q;
  assign busy = (state_q == ST_PLAY);
  assign done = (state_q == ST_FIN);
  assign step = step_q;

endmodule

// File: doc/ab_seq_gen.md
AB_SEQ_GEN -- requirements
Module: ab_seq_gen

Interface
REQ-001 Parameter DEPTH, default 8, is the number of program entries; it SHALL be a power of two, at least 2.
REQ-002 Parameter HOLD_W, default 6, is the width of the per-entry hold count.
REQ-003 Port clk, input, 1, SHALL be the single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1, SHALL be the reset: synchronous, active-low.
REQ-005 Port wr_en, input, 1, SHALL write wr_data into entry wr_addr on a rising edge.
REQ-006 Port wr_addr, input, log2(DEPTH), SHALL select the entry to write.
REQ-007 Port wr_data, input, HOLD_W+2, SHALL carry the entry as {A, B, hold}: A at the MSB, B next, hold in the low HOLD_W bits.
REQ-008 Port len, input, log2(DEPTH), SHALL give the index of the last entry played; it is sampled on start.
REQ-009 Port start, input, 1, SHALL request playback from entry 0.
REQ-010 Port loop, input, 1, SHALL request repeat after the last entry; it is sampled on start.
REQ-011 Port stop, input, 1, SHALL abort playback.
REQ-012 Ports A and B, output, 1 each, SHALL be the registered serial stimulus lines.
REQ-013 Port busy, output, 1, SHALL be high while in PLAY.
REQ-014 Port done, output, 1, SHALL pulse high for one cycle when a non-loop program completes.
REQ-015 Port step, output, log2(DEPTH), SHALL give the index of the entry currently driven.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, PLAY and FIN.
REQ-017 In IDLE, start=1 with stop=0 SHALL capture len and loop, load entry 0, and enter PLAY. In the next cycle A and B SHALL equal entry 0, busy=1 and step=0.
REQ-018 In IDLE, start=1 with stop=1 SHALL have no effect; stop wins.
REQ-019 Each entry SHALL drive A and B for exactly hold+1 consecutive cycles. hold=0 gives 1 cycle; hold=2^HOLD_W-1 gives 2^HOLD_W cycles.
REQ-020 After the final cycle of entry k < captured len, the next cycle SHALL drive entry k+1 with no gap.
REQ-021 After the final cycle of entry len, with loop captured as 1, the next cycle SHALL drive entry 0 with no gap, and done SHALL stay 0.
REQ-022 After the final cycle of entry len, with loop captured as 0, the FSM SHALL enter FIN. For that one cycle A=B=0, busy=0, done=1, step=0. It then returns to IDLE.
REQ-023 stop=1 in PLAY SHALL cause IDLE on the next edge: A=B=0, busy=0, step=0, and no done pulse.
REQ-024 start in PLAY or FIN SHALL be ignored. Changes to len or loop during PLAY SHALL have no effect.
REQ-025 wr_en during PLAY SHALL be ignored, so the program stays unchanged. wr_en in IDLE or FIN SHALL write.
REQ-026 A write and a start in the same IDLE cycle SHALL both take effect. Playback SHALL use the new value if the written entry is 0.
REQ-027 len=0 SHALL play entry 0 only.
REQ-028 The hold counter SHALL be HOLD_W bits wide, count down from the entry's hold value, and never wrap.
REQ-029 In IDLE, outputs SHALL be A=B=0, busy=0, done=0 and step=0.

Reset
REQ-030 rst=0 at a rising edge SHALL force IDLE, A=B=0, busy=0, done=0, step=0 and hold counter=0. The captured len and loop values SHALL be cleared.
REQ-031 Reset SHALL take priority over every other input, including mid-PLAY. No done pulse SHALL follow a reset.
REQ-032 Program memory contents SHALL NOT be cleared by reset.

Structure
REQ-033 The state encoding (IDLE, PLAY, FIN) and the default DEPTH and HOLD_W constants SHALL live in the shared package ab_seq_pkg.
REQ-034 The program memory SHALL be one sub-module, ab_seq_mem: DEPTH x (HOLD_W+2), one synchronous write port, one combinational read port. The FSM and counters SHALL live in ab_seq_gen.

Verification
REQ-035 Load {1,0,2}, {0,1,0}, {1,1,1}; len=2, loop=0; start -> A,B = 10,10,10,01,11,11, then done=1 for 1 cycle, then IDLE.
REQ-036 Same program with loop=1 -> sequence 10,10,10,01,11,11 repeats with no gap. Assert stop in 5th cycle of 2nd pass -> A=B=0, busy=0 next cycle, done never high.
REQ-037 rst=0 during 3rd cycle of PLAY -> next cycle A=B=0, busy=0, step=0. Restart after rst=1 -> plays the original program, which is retained.
REQ-038 Entry 0 = {1,1,63}, len=0 -> A=B=1 for exactly 64 cycles, then done pulse.
REQ-039 start with stop in IDLE -> remains IDLE. start and wr_en to entry 0 in PLAY -> both ignored; the next run uses the old entry 0.
REQ-040 start held high continuously with loop=0 -> exactly one done per run. A new run begins one cycle after FIN (IDLE sees start).
